// File: rtl/pulse_playback_engine.sv
// Pulse playback engine: accepts one pulse command (address, length, gain),
// prefetches IQ envelope samples from a synchronous waveform RAM, scales each
// half by a signed Q1.15 gain with round-half-up and saturation, and streams
// the results through a small output FIFO on a valid/ready interface.
module pulse_playback_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [15:0]       cmd_gain,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] iq_sample,
  output logic              valid_iq,
  output logic              last_iq,
  input  logic              ready_iq,
  output logic              busy,
  output logic              done
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = HALF_W + 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic signed [PROD_W-1:0] ROUND = PROD_W'(16384);
  localparam logic signed [PROD_W-1:0] MAXV  = PROD_W'((1 << (HALF_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] MINV  = -PROD_W'(1 << (HALF_W - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    left_q;      // reads still to be issued
  logic signed [15:0]  gain_q;
  logic                rd_vld_q;    // a read issued last cycle returns now
  logic                rd_last_q;   // that read was the command's final sample
  logic                done_q;

  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];  // {last, sample}
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                cmd_fire, rd_fire, push, pop, final_pop, credit_ok;
  logic [CNT_W-1:0]    occupancy;
  logic [DATA_W:0]     head;
  logic [DATA_W-1:0]   scaled;

  // Q1.15 scaling of one signed half: round half up, then saturate.
  function automatic logic [HALF_W-1:0] scale_half(input logic signed [HALF_W-1:0] h,
                                                   input logic signed [15:0]       g);
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] r;
    p = PROD_W'(h) * PROD_W'(g);
    r = (p + ROUND) >>> 15;
    if (r > MAXV)      r = MAXV;
    else if (r < MINV) r = MINV;
    return r[HALF_W-1:0];
  endfunction

  assign scaled = {scale_half(mem_rdata[DATA_W-1:HALF_W], gain_q),
                   scale_half(mem_rdata[HALF_W-1:0], gain_q)};

  // Credit counts both buffered samples and the read still in flight.
  assign occupancy = count_q + CNT_W'(rd_vld_q);
  assign credit_ok = occupancy < CNT_W'(FIFO_DEPTH);

  assign head      = fifo_mem[rd_ptr_q];
  assign valid_iq  = rst_n && (count_q != '0);
  assign iq_sample = valid_iq ? head[DATA_W-1:0] : '0;
  assign last_iq   = valid_iq && head[DATA_W];
  assign pop       = valid_iq && ready_iq;
  assign push      = rd_vld_q;
  assign final_pop = pop && head[DATA_W];

  assign cmd_ready = rst_n && (state_q == S_IDLE) && !abort;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign mem_en    = rd_fire;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  // Next-state and read-issue decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    rd_fire = 1'b0;
    unique case (state_q)
      S_IDLE:  if (cmd_fire && (cmd_len != '0)) state_d = S_RUN;
      S_RUN: begin
        rd_fire = credit_ok;
        if (credit_ok && (left_q == LEN_W'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: if (final_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // State, command registers, read tracking and completion pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      gain_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= rd_fire && !abort;
      rd_last_q <= rd_fire && (left_q == LEN_W'(1));
      done_q    <= !abort && ((cmd_fire && (cmd_len == '0)) ||
                              ((state_q == S_DRAIN) && final_pop));
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        left_q <= cmd_len;
        gain_q <= cmd_gain;
      end else if (rd_fire) begin
        addr_q <= addr_q + 1'b1;  // wraps modulo 2^ADDR_W
        left_q <= left_q - 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; abort flushes alongside reset.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: returned RAM data is scaled and written the cycle it arrives.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count gates every read of it.
    if (push) fifo_mem[wr_ptr_q] <= {rd_last_q, scaled};
  end

endmodule

// File: tb/tb_pulse_playback_engine.sv
// Self-checking bench for pulse_playback_engine: directed scenarios plus a
// randomized command stream, scored against a queue-based reference model.
module tb_pulse_playback_engine;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n, cmd_valid, cmd_ready, abort, mem_en;
  logic              valid_iq, last_iq, ready_iq, busy, done;
  logic [ADDR_W-1:0] cmd_addr, mem_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [15:0]       cmd_gain;
  logic [DATA_W-1:0] mem_rdata, iq_sample;

  pulse_playback_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_gain(cmd_gain), .abort(abort),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .iq_sample(iq_sample), .valid_iq(valid_iq), .last_iq(last_iq),
    .ready_iq(ready_iq), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Waveform RAM model: one-cycle read latency, poison value when not enabled.
  logic [31:0] ram [1024];
  always @(posedge clk) mem_rdata <= mem_en ? ram[mem_addr] : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference scaling from the arithmetic definition.
  function automatic logic [15:0] ref_half(input logic [15:0] h, input logic [15:0] g);
    longint p, q;
    p = longint'($signed(h)) * longint'($signed(g)) + 16384;
    q = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w, input logic [15:0] g);
    return {ref_half(w[31:16], g), ref_half(w[15:0], g)};
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  // Reference model state, owned by the monitor.
  exp_t        exp_q[$];
  logic [9:0]  rd_q[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];
  logic [9:0]  rd_log[$];
  int          hs_log[$];
  int          cyc = 0, outstanding = 0, done_cnt = 0, pops_total = 0;
  int          chk_mem_at = -1, chk_val_at = -1, n_len = 0, a_idx = 0;
  logic        m_busy = 1'b0, m_done_exp = 1'b0, nxt_busy, nxt_done;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_sample = '0;
  exp_t        e;

  // Monitor: samples on the falling edge and scores every cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_valid", 32'(valid_iq), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      exp_q.delete(); rd_q.delete();
      outstanding = 0; m_busy = 1'b0; m_done_exp = 1'b0; prev_stall = 1'b0;
      chk_mem_at = -1; chk_val_at = -1;
    end else begin
      nxt_busy = m_busy;
      nxt_done = 1'b0;
      check("done", 32'(done), 32'(m_done_exp));
      check("busy", 32'(busy), 32'(m_busy));
      check("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !abort));
      if (cyc == chk_mem_at) check("first_read_latency", 32'(mem_en), 1);
      if (cyc == chk_val_at) check("first_valid_latency", 32'(valid_iq), 1);
      if (mem_en) begin
        if (rd_q.size() == 0) check("spurious_read", 32'(mem_en), 0);
        else check("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
        check("credit", outstanding, outstanding < DEPTH ? outstanding : DEPTH - 1);
        rd_log.push_back(mem_addr);
        outstanding++;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(valid_iq), 1);
        check("stall_data", iq_sample, prev_sample);
        check("stall_last", 32'(last_iq), 32'(prev_last));
      end
      if (valid_iq && exp_q.size() == 0) begin
        check("spurious_valid", 32'(valid_iq), 0);
      end else if (valid_iq && ready_iq) begin
        e = exp_q.pop_front();
        check("sample", iq_sample, e.data);
        check("last", 32'(last_iq), 32'(e.last));
        pop_log.push_back(iq_sample);
        pop_cyc.push_back(cyc);
        pops_total++;
        outstanding--;
        if (e.last) begin nxt_done = 1'b1; nxt_busy = 1'b0; end
      end
      prev_stall  = valid_iq && !ready_iq;
      prev_sample = iq_sample;
      prev_last   = last_iq;
      if (cmd_valid && cmd_ready) begin
        hs_log.push_back(cyc);
        n_len = int'(cmd_len);
        for (int i = 0; i < n_len; i++) begin
          a_idx = (int'(cmd_addr) + i) % 1024;
          rd_q.push_back(10'(a_idx));
          exp_q.push_back('{data: ref_word(ram[a_idx], cmd_gain), last: (i == n_len - 1)});
        end
        if (n_len == 0) nxt_done = 1'b1;
        else begin nxt_busy = 1'b1; chk_mem_at = cyc + 1; chk_val_at = cyc + 3; end
      end
      if (abort) begin
        exp_q.delete(); rd_q.delete();
        outstanding = 0; nxt_busy = 1'b0; nxt_done = 1'b0; prev_stall = 1'b0;
        chk_mem_at = -1; chk_val_at = -1;
      end
      if (done) done_cnt++;
      m_busy     = nxt_busy;
      m_done_exp = nxt_done;
    end
  end

  logic rand_ready = 1'b0;

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready_iq = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_cmd(input logic [9:0] a, input logic [9:0] l, input logic [15:0] g);
    logic ok;
    ok = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_gain = g;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
      tick();
    end
    check("cmd_accept_timeout", 32'(ok), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!m_busy && !m_done_exp && exp_q.size() == 0 && rd_q.size() == 0) break;
    end
    check("idle_timeout", 32'(m_busy), 0);
  endtask

  task automatic wait_pops(input int target);
    for (int k = 0; k < 200; k++) begin
      if (pops_total >= target) break;
      tick();
    end
    check("pop_timeout", 32'(pops_total >= target), 1);
  endtask

  int pb, rb, hb, dc, base;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_gain = '0;
    abort = 1'b0; ready_iq = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      if (i % 16 == 5) ram[i] = 32'h8000_8000;
      if (i % 16 == 9) ram[i] = 32'h7FFF_7FFF;
    end
    for (int i = 16; i < 20; i++) ram[i] = 32'h1000_F000;
    ram[32] = 32'h8000_8000;
    ram[33] = 32'h7FFF_0001;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_mem_en", 32'(mem_en), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_valid", 32'(valid_iq), 0);
    check("reset_sample", iq_sample, 0);
    check("reset_cmd_ready", 32'(cmd_ready), 1);

    // Basic playback with exact latency and back-to-back samples.
    pb = pop_log.size(); rb = rd_log.size();
    send_cmd(10'h010, 10'd4, 16'h4000);
    wait_idle();
    check("basic_count", pop_log.size() - pb, 4);
    for (int i = 0; i < 4; i++) begin
      check("basic_data", pop_log[pb + i], 32'h0800_F800);
      check("basic_timing", pop_cyc[pb + i] - hs_log[hs_log.size() - 1], 3 + i);
      check("basic_addr", 32'(rd_log[rb + i]), 32'h10 + i);
    end

    // Saturation corners.
    pb = pop_log.size();
    send_cmd(10'h020, 10'd1, 16'h8000);
    wait_idle();
    send_cmd(10'h021, 10'd1, 16'h7FFF);
    wait_idle();
    check("sat_count", pop_log.size() - pb, 2);
    check("sat_neg_one", pop_log[pb], 32'h7FFF_7FFF);
    check("sat_max", pop_log[pb + 1], 32'h7FFE_0001);

    // Backpressure: stall from the second sample for 10 cycles.
    pb = pop_log.size(); rb = rd_log.size();
    send_cmd(10'h040, 10'd8, 16'h6000);
    wait_pops(pops_total + 1);
    ready_iq = 1'b0;
    repeat (10) tick();
    check("bp_fill", (rd_log.size() - rb) - (pop_log.size() - pb), DEPTH);
    ready_iq = 1'b1;
    wait_idle();
    check("bp_count", pop_log.size() - pb, 8);

    // Address wrap.
    rb = rd_log.size();
    send_cmd(10'h3FE, 10'd4, 16'h2345);
    wait_idle();
    check("wrap_count", rd_log.size() - rb, 4);
    check("wrap_a2", 32'(rd_log[rb + 2]), 32'h000);
    check("wrap_a3", 32'(rd_log[rb + 3]), 32'h001);

    // Zero length.
    pb = pop_log.size(); rb = rd_log.size(); dc = done_cnt;
    send_cmd(10'h123, 10'd0, 16'h4000);
    wait_idle();
    check("zero_done", done_cnt - dc, 1);
    check("zero_reads", rd_log.size() - rb, 0);
    check("zero_samples", pop_log.size() - pb, 0);

    // Abort after 3 of 8 samples, then a clean command.
    base = pops_total; dc = done_cnt;
    send_cmd(10'h100, 10'd8, 16'h5A5A);
    wait_pops(base + 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(valid_iq), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (6) tick();
    check("abort_no_done", done_cnt, dc);
    pb = pop_log.size(); rb = rd_log.size();
    send_cmd(10'h200, 10'd5, 16'h7FFF);
    wait_idle();
    check("post_abort_count", pop_log.size() - pb, 5);
    check("post_abort_addr", 32'(rd_log[rb]), 32'h200);

    // Reset after 3 of 8 samples, then a clean command.
    base = pops_total; dc = done_cnt;
    send_cmd(10'h180, 10'd8, 16'hC000);
    wait_pops(base + 3);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_valid", 32'(valid_iq), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", done_cnt, dc);
    pb = pop_log.size(); rb = rd_log.size();
    send_cmd(10'h300, 10'd6, 16'h1234);
    wait_idle();
    check("post_rst_count", pop_log.size() - pb, 6);
    check("post_rst_addr", 32'(rd_log[rb]), 32'h300);

    // Abort wins over a simultaneous command in IDLE.
    hb = hs_log.size();
    tick();
    cmd_valid = 1'b1; abort = 1'b1; cmd_addr = 10'h050; cmd_len = 10'd3;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    repeat (4) tick();
    check("abort_wins", hs_log.size(), hb);

    // Randomized command stream with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++)
      send_cmd(10'($urandom), 10'($urandom_range(0, 12)), 16'($urandom));
    wait_idle();
    rand_ready = 1'b0;
    ready_iq = 1'b1;
    repeat (3) tick();
    check("final_exp_empty", exp_q.size(), 0);
    check("final_rd_empty", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
